// File: rtl/pspi_guest.sv
// pspi_guest: device-side endpoint of the PSPI persistent-storage link.
// Decodes host frames clocked on sck (synchronized into clk), issues one
// 32-bit read or write on the local memory-request port, acknowledges the
// host and, for reads, returns the word MSB-beat first on miso.
// Optional feature: define PSPI_GUEST_ADDR_CHECK_EN to discard frames whose
// address top byte is not 8'h01; a discarded read returns 32'hFFFFFFFF.
module pspi_guest #(
    parameter int PSPI_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYC    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic [PSPI_WIDTH-1:0] mosi,
    output logic [PSPI_WIDTH-1:0] miso,
    output logic                  mreq,
    output logic                  mwe,
    output logic [31:0]           maddr,
    output logic [31:0]           mwdata,
    input  logic                  mready,
    input  logic [31:0]           mrdata,
    output logic                  abort
);
    localparam int BEATS = 32 / PSPI_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(IDLE_CYC + 1);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0]         CNT_MAX   = CW'(IDLE_CYC);
    localparam logic [CW-1:0]         CNT_FIRE  = CW'(IDLE_CYC - 1);
    localparam logic [PSPI_WIDTH-1:0] ONES      = '1;
    localparam logic [PSPI_WIDTH-1:0] ACK_VAL   = ~(PSPI_WIDTH'(1));

    typedef enum logic [2:0] {
        S_IDLE, S_RDWR, S_ADDR, S_WDATA, S_WAIT, S_ACK, S_RDATA
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [PSPI_WIDTH-1:0]  mosi_sync [SYNC_STAGES];
    logic                   sck_s, sck_d, rise, fall, timeout, addr_bad;
    logic [PSPI_WIDTH-1:0]  mosi_s;
    logic [CW-1:0]          hi_cnt;
    logic [31:0]            addr_full;

    state_t                state, state_n;
    logic [BW-1:0]         beat, beat_n;
    logic [PSPI_WIDTH-1:0] miso_n;
    logic                  mreq_n, mwe_n, abort_n;
    logic [31:0]           maddr_n, mwdata_n, rshift, rshift_n;
    logic                  ack_on, ack_on_n, abort_pend, abort_pend_n;
    logic                  discard, discard_n;

    // Append one beat at the LSB end of a word (MSB-first wire order).
    function automatic logic [31:0] shift_in(input logic [31:0] w,
                                             input logic [PSPI_WIDTH-1:0] b);
        return (w << PSPI_WIDTH) | 32'(b);
    endfunction

    // Synchronize the asynchronous host lines and keep the previous sck for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the synchronizer chain.
        if (rst) begin
            // NOTE: the synchronizer array is reset to the bus idle level so leaving reset never fakes an edge or a start bit.
            sck_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) mosi_sync[i] <= '1;
            sck_d    <= 1'b1;
        end else begin
            sck_sync[0]  <= sck;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_d <= sck_s;
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;
    assign addr_full = shift_in(maddr, mosi_s);

`ifdef PSPI_GUEST_ADDR_CHECK_EN
    assign addr_bad = (addr_full[31:24] != 8'h01);
`else
    assign addr_bad = 1'b0;
`endif

    // Count cycles of synchronized sck high; the count saturates so timeout fires once per high period.
    always_ff @(posedge clk) begin
        if (rst || !sck_s) hi_cnt <= '0;
        else if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CW'(1);
    end

    // abort lands exactly IDLE_CYC cycles after the synchronized rise.
    assign timeout = sck_s && (hi_cnt == CNT_FIRE);

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            miso       <= ONES;
            mreq       <= 1'b0;
            mwe        <= 1'b0;
            maddr      <= '0;
            mwdata     <= '0;
            abort      <= 1'b0;
            ack_on     <= 1'b0;
            abort_pend <= 1'b0;
            discard    <= 1'b0;
            rshift     <= '0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            miso       <= miso_n;
            mreq       <= mreq_n;
            mwe        <= mwe_n;
            maddr      <= maddr_n;
            mwdata     <= mwdata_n;
            abort      <= abort_n;
            ack_on     <= ack_on_n;
            abort_pend <= abort_pend_n;
            discard    <= discard_n;
            rshift     <= rshift_n;
        end
    end

    // Next-state and next-register logic, driven by the sck rise/fall events.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_n      = state;
        beat_n       = beat;
        miso_n       = miso;
        mreq_n       = mreq;
        mwe_n        = mwe;
        maddr_n      = maddr;
        mwdata_n     = mwdata;
        abort_n      = 1'b0;
        ack_on_n     = ack_on;
        abort_pend_n = abort_pend;
        discard_n    = discard;
        rshift_n     = rshift;
        unique case (state)
            S_IDLE: begin
                miso_n       = ONES;
                ack_on_n     = 1'b0;
                abort_pend_n = 1'b0;
                if (rise && !mosi_s[0]) state_n = S_RDWR;
            end
            S_RDWR: if (rise) begin
                mwe_n     = mosi_s[0];
                beat_n    = '0;
                discard_n = 1'b0;
                state_n   = S_ADDR;
            end
            S_ADDR: if (rise) begin
                maddr_n = addr_full;
                if (beat == LAST_BEAT) begin
                    beat_n    = '0;
                    discard_n = addr_bad;
                    if (mwe) begin
                        state_n = S_WDATA;
                    end else if (addr_bad) begin
                        state_n  = S_ACK;
                        rshift_n = '1;
                    end else begin
                        state_n = S_WAIT;
                        mreq_n  = 1'b1;
                    end
                end else begin
                    beat_n = beat + BW'(1);
                end
            end
            S_WDATA: if (rise) begin
                mwdata_n = shift_in(mwdata, mosi_s);
                if (beat == LAST_BEAT) begin
                    beat_n = '0;
                    if (discard) begin
                        state_n = S_ACK;
                    end else begin
                        state_n = S_WAIT;
                        mreq_n  = 1'b1;
                    end
                end else begin
                    beat_n = beat + BW'(1);
                end
            end
            S_WAIT: begin
                // The backend access always completes before a pending abort takes effect.
                if (mready) begin
                    mreq_n       = 1'b0;
                    rshift_n     = mrdata;
                    abort_pend_n = 1'b0;
                    if (abort_pend || timeout) begin
                        abort_n = 1'b1;
                        miso_n  = ONES;
                        state_n = S_IDLE;
                    end else begin
                        ack_on_n = 1'b0;
                        state_n  = S_ACK;
                    end
                end else if (timeout) begin
                    abort_pend_n = 1'b1;
                end
            end
            S_ACK: if (fall) begin
                // The ack is held from one fall to the next so the host sees it for a full period.
                if (!ack_on) begin
                    miso_n   = ACK_VAL;
                    ack_on_n = 1'b1;
                end else begin
                    ack_on_n = 1'b0;
                    if (mwe) begin
                        miso_n  = ONES;
                        state_n = S_IDLE;
                    end else begin
                        miso_n   = rshift[31 -: PSPI_WIDTH];
                        rshift_n = rshift << PSPI_WIDTH;
                        beat_n   = '0;
                        state_n  = S_RDATA;
                    end
                end
            end
            S_RDATA: begin
                if (fall) begin
                    miso_n   = rshift[31 -: PSPI_WIDTH];
                    rshift_n = rshift << PSPI_WIDTH;
                end
                if (rise) begin
                    if (beat == LAST_BEAT) begin
                        miso_n  = ONES;
                        state_n = S_IDLE;
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (timeout && state != S_IDLE && state != S_WAIT) begin
            abort_n  = 1'b1;
            miso_n   = ONES;
            beat_n   = '0;
            ack_on_n = 1'b0;
            state_n  = S_IDLE;
        end
    end
endmodule
